riscv_alu_seq: RTL and testbench

RISCV_ALU_SEQ -- requirements
Module: riscv_alu_seq

---
 rtl/riscv_alu_seq.sv | 162 ++++++++++++++++
 tb/tb_riscv_alu_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_alu_seq.sv
// riscv_alu_seq: handshaked RV32-style ALU. Single-cycle ops answer in one cycle; with
// RISCV_ALU_M_EXT_EN defined, mul/div run a bit-serial datapath for WORD_LENGTH cycles.
package riscv_constants;
   typedef enum logic [4:0] {
      ALU_ADD = 5'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_SLT, ALU_SLTU, ALU_MUL, ALU_MULH, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
   } exec_fun_e;
endpackage

module riscv_alu_seq
   import riscv_constants::*;
#(
   parameter int WORD_LENGTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  exec_fun_e              exec_fun,
   input  logic [WORD_LENGTH-1:0] data1,
   input  logic [WORD_LENGTH-1:0] data2,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [WORD_LENGTH-1:0] alu_out,
   output logic                   br_flag,
   output logic                   out_valid,
   input  logic                   out_ready
);
   localparam int W  = WORD_LENGTH;
   localparam int SW = $clog2(W);

`ifdef RISCV_ALU_M_EXT_EN
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
`else
   typedef enum logic [1:0] {IDLE, DONE} state_e;
`endif

   state_e        state;
   logic [SW-1:0] shamt;
   logic [W-1:0]  simple_res;

   assign in_ready = (state == IDLE);
   assign shamt    = data2[SW-1:0];

   always_comb begin
      simple_res = '0;
      case (exec_fun)
         ALU_ADD:  simple_res = data1 + data2;
         ALU_SUB:  simple_res = data1 - data2;
         ALU_AND:  simple_res = data1 & data2;
         ALU_OR:   simple_res = data1 | data2;
         ALU_XOR:  simple_res = data1 ^ data2;
         ALU_SLL:  simple_res = data1 << shamt;
         ALU_SRL:  simple_res = data1 >> shamt;
         ALU_SRA:  simple_res = $unsigned($signed(data1) >>> shamt);
         ALU_SLT:  simple_res = {{(W-1){1'b0}}, ($signed(data1) < $signed(data2))};
         ALU_SLTU: simple_res = {{(W-1){1'b0}}, (data1 < data2)};
         default:  simple_res = '0;
      endcase
   end

`ifdef RISCV_ALU_M_EXT_EN
   typedef struct packed {
      exec_fun_e    fun;
      logic [W-1:0] a;
      logic         neg_q;   // negate product / quotient at the end
      logic         neg_r;   // negate remainder (dividend was negative)
      logic         div0;
      logic         eq;
   } req_t;

   req_t           req;
   logic [2*W-1:0] work, work_nxt, prod_fix;
   logic [W-1:0]   mag_b, mag_a_in, mag_b_in, diff, quo, rem, long_res;
   logic [W:0]     mul_sum, trial;
   logic [SW-1:0]  cnt;
   logic           sgn_op, ge, is_div, is_m;

   // Signed ops work on magnitudes; the sign is restored once at the end.
   assign sgn_op   = exec_fun inside {ALU_MULH, ALU_DIV, ALU_REM};
   assign is_m     = exec_fun inside {ALU_MUL, ALU_MULH, ALU_MULHU, ALU_DIV, ALU_DIVU,
                                      ALU_REM, ALU_REMU};
   assign mag_a_in = (sgn_op && data1[W-1]) ? -data1 : data1;
   assign mag_b_in = (sgn_op && data2[W-1]) ? -data2 : data2;

   // work = {hi, lo}: shift-add keeps {partial product, multiplier};
   // restoring divide keeps {remainder, dividend/quotient}.
   always_comb begin
      is_div   = req.fun inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
      mul_sum  = {1'b0, work[2*W-1:W]} + (work[0] ? {1'b0, mag_b} : '0);
      trial    = {work[2*W-1:W], work[W-1]};
      ge       = (trial >= {1'b0, mag_b});
      diff     = trial[W-1:0] - mag_b;
      work_nxt = is_div ? {(ge ? diff : trial[W-1:0]), work[W-2:0], ge}
                        : {mul_sum, work[W-1:1]};
      prod_fix = req.neg_q ? -work_nxt : work_nxt;
      quo      = req.neg_q ? -work_nxt[W-1:0] : work_nxt[W-1:0];
      rem      = req.neg_r ? -work_nxt[2*W-1:W] : work_nxt[2*W-1:W];
      long_res = '0;
      case (req.fun)
         ALU_MUL:            long_res = prod_fix[W-1:0];
         ALU_MULH, ALU_MULHU: long_res = prod_fix[2*W-1:W];
         ALU_DIV, ALU_DIVU:  long_res = req.div0 ? '1 : quo;
         ALU_REM, ALU_REMU:  long_res = req.div0 ? req.a : rem;
         default:            long_res = '0;
      endcase
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         alu_out   <= '0;
         br_flag   <= 1'b0;
`ifdef RISCV_ALU_M_EXT_EN
         cnt       <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
`ifdef RISCV_ALU_M_EXT_EN
               if (is_m) begin
                  state     <= CALC;
                  cnt       <= '0;
                  work      <= {{W{1'b0}}, mag_a_in};
                  mag_b     <= mag_b_in;
                  req.fun   <= exec_fun;
                  req.a     <= data1;
                  req.neg_q <= sgn_op && (data1[W-1] ^ data2[W-1]);
                  req.neg_r <= sgn_op && data1[W-1];
                  req.div0  <= (data2 == '0);
                  req.eq    <= (data1 == data2);
               end else begin
`else
               begin
`endif
                  state     <= DONE;
                  out_valid <= 1'b1;
                  alu_out   <= simple_res;
                  br_flag   <= (data1 == data2);
               end
            end
`ifdef RISCV_ALU_M_EXT_EN
            CALC: begin
               work <= work_nxt;
               cnt  <= cnt + 1'b1;
               if (cnt == SW'(W-1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  alu_out   <= long_res;
                  br_flag   <= req.eq;
               end
            end
`endif
            DONE: if (out_ready) begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_riscv_alu_seq.sv
// tb_riscv_alu_seq: directed vectors with literal expectations plus a transaction-level
// reference model checked every cycle; follows RISCV_ALU_M_EXT_EN like the design.
module tb_riscv_alu_seq;
   import riscv_constants::*;
   localparam int W = 32;
`ifdef RISCV_ALU_M_EXT_EN
   localparam bit M_EN = 1'b1;
`else
   localparam bit M_EN = 1'b0;
`endif
   localparam int ML = M_EN ? W + 1 : 1;

   logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   exec_fun_e    exec_fun = ALU_ADD;
   logic [W-1:0] data1 = '0, data2 = '0;
   logic         in_ready, out_valid, br_flag;
   logic [W-1:0] alu_out;
   int           n_chk = 0, n_fail = 0;
   bit           chk_en = 1'b0;

   always #5 clk = ~clk;

   riscv_alu_seq #(.WORD_LENGTH(W)) dut (
      .clk(clk), .rst(rst), .exec_fun(exec_fun), .data1(data1), .data2(data2),
      .in_valid(in_valid), .in_ready(in_ready), .alu_out(alu_out), .br_flag(br_flag),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic bit is_long(exec_fun_e f);
      return M_EN && (f inside {ALU_MUL, ALU_MULH, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU});
   endfunction

   // Reference arithmetic from the ISA definitions, done in 64-bit integers.
   function automatic logic [W-1:0] model_res(exec_fun_e f, logic [W-1:0] a, logic [W-1:0] b);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      logic [63:0]     p;
      case (f)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_SLL:  return a << b[4:0];
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return W'(sa >>> b[4:0]);
         ALU_SLT:  return (sa < sb) ? 1 : 0;
         ALU_SLTU: return (a < b) ? 1 : 0;
         default: begin
            if (!M_EN) return '0;
            case (f)
               ALU_MUL:   begin p = ua * ub;        return p[31:0];  end
               ALU_MULH:  begin p = 64'(sa * sb);   return p[63:32]; end
               ALU_MULHU: begin p = ua * ub;        return p[63:32]; end
               ALU_DIV:   return (b == 0) ? '1 : W'(sa / sb);
               ALU_REM:   return (b == 0) ? a  : W'(sa % sb);
               ALU_DIVU:  return (b == 0) ? '1 : W'(ua / ub);
               ALU_REMU:  return (b == 0) ? a  : W'(ua % ub);
               default:   return '0;
            endcase
         end
      endcase
   endfunction

   // Transaction model: expected readiness, result timing and value.
   bit           m_idle = 1'b1, m_valid = 1'b0, m_br = 1'b0;
   int           m_wait = 0;
   logic [W-1:0] m_res = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_idle = 1'b1; m_valid = 1'b0; m_wait = 0;
      end else if (m_valid) begin
         if (out_ready) begin m_valid = 1'b0; m_idle = 1'b1; end
      end else if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) m_valid = 1'b1;
      end else if (m_idle && in_valid) begin
         m_res  = model_res(exec_fun, data1, data2);
         m_br   = (data1 == data2);
         m_idle = 1'b0;
         if (is_long(exec_fun)) m_wait = W;
         else m_valid = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_in_ready", in_ready, m_idle);
         chk("model_out_valid", out_valid, m_valid);
         if (m_valid) begin
            chk("model_alu_out", alu_out, m_res);
            chk("model_br_flag", br_flag, m_br);
         end
      end
   end

   task automatic run_op(input string name, input exec_fun_e f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp, input bit exp_br,
                         input int exp_lat, input int hold);
      int lat;
      @(negedge clk);
      exec_fun = f; data1 = a; data2 = b; in_valid = 1'b1; out_ready = (hold == 0);
      chk({name, "_in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         // junk requests while busy must be ignored
         in_valid = 1'b1; exec_fun = ALU_SUB; data1 = $urandom; data2 = $urandom;
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      chk({name, "_latency"}, lat, exp_lat);
      chk({name, "_alu_out"}, alu_out, exp);
      chk({name, "_br_flag"}, br_flag, exp_br);
      chk({name, "_busy"}, in_ready, 0);
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1; data1 = $urandom;
         @(posedge clk); #1;
         chk({name, "_hold_valid"}, out_valid, 1);
         chk({name, "_hold_out"}, alu_out, exp);
         chk({name, "_hold_ready"}, in_ready, 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk({name, "_consumed"}, out_valid, 0);
   endtask

   task automatic rst_abort(input exec_fun_e f, input logic [W-1:0] a, input logic [W-1:0] b);
      bit seen;
      @(negedge clk);
      exec_fun = f; data1 = a; data2 = b; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_alu_out", alu_out, 0);
      chk("abort_br_flag", br_flag, 0);
      out_ready = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("abort_no_result", seen, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_alu_out", alu_out, 0);
      chk("reset_br_flag", br_flag, 0);
      chk("reset_in_ready", in_ready, 1);
      rst = 1'b0;
      chk_en = 1'b1;

      run_op("add",   ALU_ADD,  32'd5,        32'd7,        32'd12,       1'b0, 1, 0);
      run_op("sub",   ALU_SUB,  32'd9,        32'd9,        32'd0,        1'b1, 1, 0);
      run_op("sra",   ALU_SRA,  32'h80000000, 32'h24,       32'hF8000000, 1'b0, 1, 0);
      run_op("slt",   ALU_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1, 0);
      run_op("sltu",  ALU_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1, 0);
      run_op("sll",   ALU_SLL,  32'd1,        32'h21,       32'd2,        1'b0, 1, 0);
      run_op("srl",   ALU_SRL,  32'h80000000, 32'd31,       32'd1,        1'b0, 1, 0);
      run_op("and",   ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1, 0);
      run_op("or",    ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1, 0);
      run_op("xor",   ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1, 0);
      run_op("addwr", ALU_ADD,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1, 0);
      run_op("unlst", exec_fun_e'(5'd25), 32'd5, 32'd5,     32'd0,        1'b1, 1, 0);
      run_op("hold",  ALU_ADD,  32'd5,        32'd7,        32'd12,       1'b0, 1, 5);
`ifdef RISCV_ALU_M_EXT_EN
      run_op("mul",   ALU_MUL,   32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b0, ML, 0);
      run_op("mulhu", ALU_MULHU, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, ML, 0);
      run_op("mulh",  ALU_MULH,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, ML, 0);
      run_op("mul2",  ALU_MUL,   32'h12345678, 32'h100,      32'h34567800, 1'b0, ML, 0);
      run_op("mulhu2",ALU_MULHU, 32'h12345678, 32'h100,      32'h12,       1'b0, ML, 0);
      run_op("divov", ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, ML, 0);
      run_op("remov", ALU_REM,   32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, ML, 0);
      run_op("divu0", ALU_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 1'b0, ML, 0);
      run_op("remu0", ALU_REMU,  32'd7,        32'd0,        32'd7,        1'b0, ML, 0);
      run_op("remneg",ALU_REM,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, ML, 0);
      run_op("divneg",ALU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, ML, 0);
      run_op("div0",  ALU_DIV,   32'd7,        32'd0,        32'hFFFFFFFF, 1'b0, ML, 0);
      run_op("rem0",  ALU_REM,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b0, ML, 0);
      run_op("divu",  ALU_DIVU,  32'd100,      32'd7,        32'd14,       1'b0, ML, 0);
      run_op("remu",  ALU_REMU,  32'd100,      32'd7,        32'd2,        1'b0, ML, 3);
      rst_abort(ALU_DIV, 32'd1000, 32'd3);
`else
      run_op("mul",   ALU_MUL,   32'd3,        32'd4,        32'd0,        1'b0, 1, 0);
      run_op("mulhu", ALU_MULHU, 32'hFFFFFFFF, 32'd2,        32'd0,        1'b0, 1, 0);
      run_op("div",   ALU_DIV,   32'd7,        32'd0,        32'd0,        1'b0, 1, 0);
      rst_abort(ALU_ADD, 32'd1000, 32'd3);
`endif
      run_op("post",  ALU_ADD,  32'd40,       32'd2,        32'd42,       1'b0, 1, 0);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
